// File: rtl/bit_serial_adder.sv
// bit_serial_adder -- LSB-first sequential adder, one result bit per clock.
//
// Each clock during an addition does one full-add. The full-add is built from
// two half-add cells. The carry is kept in a flop between bit steps. The result
// is {carry,sum} = A + B + cin, unsigned, modulo 2^(WIDTH+1).
//
// Optional feature macro: BIT_SERIAL_ADDER_OVF_EN
//   When it is defined, the block adds a registered signed-overflow output, ovf.
//   ovf = (carry into the MSB) ^ (carry out of the MSB).
//   When it is not defined, the port and its logic are absent.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 1), default 8
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset; has priority over every other input
//   start  begin an addition; sampled only while idle
//   A, B   operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while an addition is in flight
//   done   one-cycle pulse; sum/carry (and ovf) were just updated
//   sum    result of the last completed addition
//   ovf    (macro only) two's-complement overflow of the last addition
//   carry  carry-out of the last completed addition
//
// Timing: the accepting edge is E0. The edges E1..E_WIDTH each process one bit.
// done is high in the cycle that follows E_WIDTH. If start is high in that done
// cycle, the block accepts the next addition.

// Combinational half-add cell.
module bsa_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// Full-add made from two half-add cells:
//   s  = a ^ b ^ ci
//   co = a&b | ci&(a^b)
module bsa_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  bsa_half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  bsa_half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             carry
);

  // The counter holds values 0..WIDTH-1. This width leaves room for WIDTH,
  // so the counter never wraps inside one addition.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state;
  logic [WIDTH-1:0] sha;      // operand A, shifted right one bit per step
  logic [WIDTH-1:0] shb;      // operand B, shifted right one bit per step
  logic [WIDTH-1:0] res;      // partial result, filled from the MSB downward
  logic [WIDTH-1:0] res_nxt;
  logic             cf;       // carry between bit steps
  logic [CW-1:0]    cnt;      // bit steps already done in this addition
  logic             fa_s;
  logic             fa_co;
  logic             last;

  bsa_full_adder u_fa (
    .a  (sha[0]),
    .b  (shb[0]),
    .ci (cf),
    .s  (fa_s),
    .co (fa_co)
  );

  // Insert the new bit at the MSB. After WIDTH steps, the first bit (the LSB
  // result) has moved down to bit 0. This form also works for WIDTH=1.
  always_comb begin
    res_nxt            = res >> 1;
    res_nxt[WIDTH-1]   = fa_s;
  end

  // The step now being processed is the WIDTH-th, so it handles the MSB.
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sha   <= '0;
      shb   <= '0;
      res   <= '0;
      cf    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      // done is a pulse. A completion edge below sets it again.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sha   <= A;
            shb   <= B;
            cf    <= cin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          // Once accepted, the operands are used only from the shift
          // registers. Changes on A/B/start cannot disturb this addition.
          sha <= sha >> 1;
          shb <= shb >> 1;
          res <= res_nxt;
          cf  <= fa_co;
          cnt <= cnt + CW'(1);
          if (last) begin
            sum   <= res_nxt;
            carry <= fa_co;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            // cf is the carry into the MSB position on this step.
            ovf   <= cf ^ fa_co;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
